// File: rtl/psg_stereo_mixer.sv
// rtl/psg_stereo_mixer.sv - PSG three-channel mono/stereo mixer with box-average decimation
// and a single-register valid/ready output stage.
module psg_stereo_mixer #(
   parameter int DECIM_LOG2 = 3
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic        CE,
   input  logic [7:0]  CHANNEL_A,
   input  logic [7:0]  CHANNEL_B,
   input  logic [7:0]  CHANNEL_C,
   input  logic [1:0]  STEREO_MODE,
   output logic [15:0] OUT_L,
   output logic [15:0] OUT_R,
   output logic        OUT_VALID,
   input  logic        OUT_READY,
   output logic        OVERRUN,
   input  logic        CLR_OVR
);

   localparam int AW = 10 + DECIM_LOG2;
   localparam int CW = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
   localparam int N  = 1 << DECIM_LOG2;

   logic [9:0]    ch_a, ch_b, ch_c;
   logic [9:0]    mix_l, mix_r;
   logic [AW-1:0] acc_l, acc_r;
   logic [AW-1:0] tot_l, tot_r;
   logic [9:0]    avg_l, avg_r;
   logic [CW-1:0] win_cnt;
   logic          window_end;
   logic          accepted;

   assign ch_a = {2'b00, CHANNEL_A};
   assign ch_b = {2'b00, CHANNEL_B};
   assign ch_c = {2'b00, CHANNEL_C};

   always_comb begin
      mix_l = ch_a + ch_b + ch_c;
      mix_r = ch_a + ch_b + ch_c;
      case (STEREO_MODE)
         2'd1: begin
            mix_l = {ch_a[8:0], 1'b0} + ch_b;
            mix_r = {ch_c[8:0], 1'b0} + ch_b;
         end
         2'd2: begin
            mix_l = {ch_a[8:0], 1'b0} + ch_c;
            mix_r = {ch_b[8:0], 1'b0} + ch_c;
         end
         default: ;
      endcase
   end

   assign tot_l      = acc_l + AW'(mix_l);
   assign tot_r      = acc_r + AW'(mix_r);
   assign avg_l      = tot_l[DECIM_LOG2 +: 10];
   assign avg_r      = tot_r[DECIM_LOG2 +: 10];
   assign window_end = CE && (win_cnt == CW'(N - 1));
   // A completed window is taken unless an unconsumed sample is still being held.
   assign accepted   = !OUT_VALID || OUT_READY;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         acc_l   <= '0;
         acc_r   <= '0;
         win_cnt <= '0;
      end else if (window_end) begin
         acc_l   <= '0;
         acc_r   <= '0;
         win_cnt <= '0;
      end else if (CE) begin
         acc_l   <= tot_l;
         acc_r   <= tot_r;
         win_cnt <= win_cnt + CW'(1);
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         OUT_L     <= 16'h8000;
         OUT_R     <= 16'h8000;
         OUT_VALID <= 1'b0;
         OVERRUN   <= 1'b0;
      end else begin
         if (window_end && accepted) begin
            OUT_L     <= {avg_l, 6'b0} ^ 16'h8000;
            OUT_R     <= {avg_r, 6'b0} ^ 16'h8000;
            OUT_VALID <= 1'b1;
         end else if (OUT_VALID && OUT_READY) begin
            OUT_VALID <= 1'b0;
         end

         if (window_end && !accepted)
            OVERRUN <= 1'b1;
         else if (CLR_OVR)
            OVERRUN <= 1'b0;
      end
   end

endmodule

// File: tb/tb_psg_stereo_mixer.sv
// tb/tb_psg_stereo_mixer.sv - scoreboard bench for psg_stereo_mixer at DECIM_LOG2 = 3.
module tb_psg_stereo_mixer;

   logic        CLK = 1'b0;
   logic        RESET_N = 1'b0;
   logic        CE = 1'b0;
   logic [7:0]  CHANNEL_A = '0;
   logic [7:0]  CHANNEL_B = '0;
   logic [7:0]  CHANNEL_C = '0;
   logic [1:0]  STEREO_MODE = '0;
   logic [15:0] OUT_L, OUT_R;
   logic        OUT_VALID;
   logic        OUT_READY = 1'b1;
   logic        OVERRUN;
   logic        CLR_OVR = 1'b0;

   int          n_tests = 0;
   int          n_fail = 0;
   logic [31:0] exp_q[$];
   logic [31:0] mon_exp;
   int unsigned mdl_l = 0, mdl_r = 0, mdl_cnt = 0;
   bit          drop_next = 0;

   psg_stereo_mixer #(.DECIM_LOG2(3)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .CE(CE),
      .CHANNEL_A(CHANNEL_A), .CHANNEL_B(CHANNEL_B), .CHANNEL_C(CHANNEL_C),
      .STEREO_MODE(STEREO_MODE),
      .OUT_L(OUT_L), .OUT_R(OUT_R), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
      .OVERRUN(OVERRUN), .CLR_OVR(CLR_OVR)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] to_sample(input int unsigned sum);
      logic [9:0] avg;
      avg = 10'(sum / 8);
      return {avg, 6'b0} ^ 16'h8000;
   endfunction

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic do_ce(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                        input logic [1:0] m);
      int unsigned l, r;
      CHANNEL_A = a; CHANNEL_B = b; CHANNEL_C = c; STEREO_MODE = m; CE = 1'b1;
      case (m)
         2'd1: begin l = 2 * int'(a) + int'(b); r = 2 * int'(c) + int'(b); end
         2'd2: begin l = 2 * int'(a) + int'(c); r = 2 * int'(b) + int'(c); end
         default: begin l = int'(a) + int'(b) + int'(c); r = l; end
      endcase
      mdl_l += l; mdl_r += r; mdl_cnt++;
      if (mdl_cnt == 8) begin
         if (!drop_next) exp_q.push_back({to_sample(mdl_l), to_sample(mdl_r)});
         drop_next = 0;
         mdl_l = 0; mdl_r = 0; mdl_cnt = 0;
      end
      @(posedge CLK);
      #1 CE = 1'b0;
   endtask

   always @(negedge CLK) begin
      if (RESET_N && OUT_VALID && OUT_READY) begin
         if (exp_q.size() == 0) begin
            check("spurious_sample", 32'd1, 32'd0);
         end else begin
            mon_exp = exp_q.pop_front();
            check("sb_out_l", {16'h0, OUT_L}, {16'h0, mon_exp[31:16]});
            check("sb_out_r", {16'h0, OUT_R}, {16'h0, mon_exp[15:0]});
         end
      end
   end

   initial begin
      idle(2);
      @(negedge CLK);
      check("rst_out_l", {16'h0, OUT_L}, 32'h8000);
      check("rst_out_r", {16'h0, OUT_R}, 32'h8000);
      check("rst_valid", {31'h0, OUT_VALID}, 32'd0);
      check("rst_overrun", {31'h0, OVERRUN}, 32'd0);
      @(posedge CLK);
      #1 RESET_N = 1'b1;
      idle(1);

      // Mono 0x55 window, one-cycle latency after the 8th CE
      for (int i = 0; i < 7; i++) do_ce(8'h55, 8'h55, 8'h55, 2'd0);
      @(negedge CLK);
      check("mono_early_valid", {31'h0, OUT_VALID}, 32'd0);
      do_ce(8'h55, 8'h55, 8'h55, 2'd0);
      @(negedge CLK);
      check("mono_valid", {31'h0, OUT_VALID}, 32'd1);
      check("mono_l", {16'h0, OUT_L}, 32'hBFC0);
      check("mono_r", {16'h0, OUT_R}, 32'hBFC0);
      idle(2);

      for (int i = 0; i < 8; i++) do_ce(8'hFF, 8'h00, 8'h00, 2'd1);
      @(negedge CLK);
      check("abc_l", {16'h0, OUT_L}, 32'hFF80);
      check("abc_r", {16'h0, OUT_R}, 32'h8000);
      idle(2);

      for (int i = 0; i < 8; i++) do_ce(8'h00, 8'hFF, 8'h00, 2'd2);
      @(negedge CLK);
      check("acb_l", {16'h0, OUT_L}, 32'h8000);
      check("acb_r", {16'h0, OUT_R}, 32'hFF80);
      idle(2);

      // Alternating 0/FF with idle cycles between CEs: truncated average 127
      for (int i = 0; i < 8; i++) begin
         do_ce((i % 2) ? 8'hFF : 8'h00, 8'h00, 8'h00, 2'd0);
         if (i < 7) idle(1);
      end
      @(negedge CLK);
      check("alt_l", {16'h0, OUT_L}, 32'h9FC0);
      idle(2);

      for (int i = 0; i < 4; i++) do_ce(8'h10, 8'h20, 8'h30, 2'd0);
      for (int i = 0; i < 4; i++) do_ce(8'h40, 8'h50, 8'h60, 2'd2);
      for (int w = 0; w < 3; w++)
         for (int i = 0; i < 8; i++)
            do_ce(8'($urandom), 8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)));
      idle(3);

      // Two window ends while the consumer stalls
      OUT_READY = 1'b0;
      for (int i = 0; i < 8; i++) do_ce(8'h55, 8'h55, 8'h55, 2'd0);
      drop_next = 1;
      for (int i = 0; i < 8; i++) do_ce(8'hFF, 8'h00, 8'h00, 2'd1);
      @(negedge CLK);
      check("ovr_set", {31'h0, OVERRUN}, 32'd1);
      check("ovr_valid", {31'h0, OUT_VALID}, 32'd1);
      check("ovr_hold_l", {16'h0, OUT_L}, 32'hBFC0);
      @(posedge CLK);
      #1 CLR_OVR = 1'b1;
      @(posedge CLK);
      #1 CLR_OVR = 1'b0;
      @(negedge CLK);
      check("ovr_clr", {31'h0, OVERRUN}, 32'd0);
      OUT_READY = 1'b1;
      idle(2);

      // Consumer takes the old sample on the same edge the new one completes
      OUT_READY = 1'b0;
      for (int i = 0; i < 8; i++) do_ce(8'h55, 8'h55, 8'h55, 2'd0);
      for (int i = 0; i < 7; i++) do_ce(8'hFF, 8'h00, 8'h00, 2'd1);
      OUT_READY = 1'b1;
      do_ce(8'hFF, 8'h00, 8'h00, 2'd1);
      @(negedge CLK);
      check("same_valid", {31'h0, OUT_VALID}, 32'd1);
      check("same_overrun", {31'h0, OVERRUN}, 32'd0);
      check("same_l", {16'h0, OUT_L}, 32'hFF80);
      idle(2);

      // Reset mid-window drops the partial accumulation
      for (int i = 0; i < 5; i++) do_ce(8'h55, 8'h55, 8'h55, 2'd0);
      RESET_N = 1'b0;
      mdl_l = 0; mdl_r = 0; mdl_cnt = 0;
      @(negedge CLK);
      check("mid_rst_l", {16'h0, OUT_L}, 32'h8000);
      check("mid_rst_r", {16'h0, OUT_R}, 32'h8000);
      check("mid_rst_valid", {31'h0, OUT_VALID}, 32'd0);
      @(posedge CLK);
      #1 RESET_N = 1'b1;
      for (int i = 0; i < 7; i++) do_ce(8'h55, 8'h55, 8'h55, 2'd0);
      @(negedge CLK);
      check("post_rst_early", {31'h0, OUT_VALID}, 32'd0);
      do_ce(8'h55, 8'h55, 8'h55, 2'd0);
      @(negedge CLK);
      check("post_rst_valid", {31'h0, OUT_VALID}, 32'd1);
      check("post_rst_l", {16'h0, OUT_L}, 32'hBFC0);

      for (int i = 0; i < 50 && exp_q.size() != 0; i++) idle(1);
      check("drain", exp_q.size(), 32'd0);
      idle(2);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
